// File: rtl/quad_pkg.sv
// quad_pkg: constants and helpers shared by the quadrature front end.
//   ctrl_state_e  : control FSM encoding (ST_STARTUP, ST_RUN)
//   SYNC_STAGES   : depth of the per-channel input synchronizer
//   is_double_step: true when both quadrature bits change in one step
package quad_pkg;

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } ctrl_state_e;

  // Two-flop synchronizer ahead of each debounce counter. This adds
  // SYNC_STAGES edges to every clean-output transition.
  localparam int SYNC_STAGES = 2;

  // A legal quadrature (Gray) step flips exactly one of {a,b}.
  // A step that flips both means the encoder skipped a state.
  function automatic logic is_double_step(input logic [1:0] ab_now,
                                          input logic [1:0] ab_next);
    return &(ab_now ^ ab_next);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one quadrature channel, synchronized and debounced.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous pin level
//   clean      : debounced level
//   flip       : high in the cycle whose rising edge will toggle clean
//   idle       : debounce counter is zero (no pending mismatch)
module debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic flip,
  output logic idle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned; that is what keeps latches from being inferred.
    s1_d     = raw;
    s2_d     = s1_q;
    clean_d  = clean_q;
    cnt_d    = '0;
    mismatch = (s2_q != clean_q);
    flip     = 1'b0;
    if (mismatch) begin
      if (cnt_q == CNT_LAST) begin
        // Mismatch has now held for DEBOUNCE_CYCLES edges: accept it.
        clean_d = s2_q;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;
  assign idle  = (cnt_q == '0);

endmodule

// File: rtl/quad_conditioner.sv
// quad_conditioner: conditions the two raw quadrature pins for the encoder.
//   clk, reset      : clock, synchronous active-high reset
//   a_raw, b_raw    : asynchronous quadrature pins
//   a, b            : debounced channels for the encoder
//   ready           : startup settling period is over
//   stable          : neither channel has a pending mismatch
//   illegal         : one-cycle pulse after both channels changed together
//   err_count       : saturating count of illegal pulses
module quad_conditioner
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int ERR_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_raw,
  input  logic             b_raw,
  output logic             a,
  output logic             b,
  output logic             ready,
  output logic             stable,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count
);

  // One extra bit so DEBOUNCE_CYCLES+SYNC_STAGES still fits when
  // DEBOUNCE_CYCLES sits at the top of its range.
  localparam int STARTUP_W = CNT_W + 1;
  localparam logic [STARTUP_W-1:0] STARTUP_LAST =
    STARTUP_W'(DEBOUNCE_CYCLES + SYNC_STAGES - 1);

  logic a_flip, b_flip, a_idle, b_idle;

  debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_chan_a (
    .clk(clk), .reset(reset), .raw(a_raw), .clean(a), .flip(a_flip), .idle(a_idle)
  );

  debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_chan_b (
    .clk(clk), .reset(reset), .raw(b_raw), .clean(b), .flip(b_flip), .idle(b_idle)
  );

  ctrl_state_e          state_q, state_d;
  logic [STARTUP_W-1:0] startup_cnt_q, startup_cnt_d;
  logic                 double_q, double_d;
  logic                 illegal_q, illegal_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;

  always_comb begin
    state_d       = state_q;
    startup_cnt_d = startup_cnt_q;
    if (state_q == ST_STARTUP) begin
      if (startup_cnt_q == STARTUP_LAST) begin
        state_d = ST_RUN;
      end else begin
        startup_cnt_d = startup_cnt_q + STARTUP_W'(1);
      end
    end

    // Qualified by the state before the edge on which the outputs move, so
    // power-up levels settling on the STARTUP->RUN edge stay silent.
    double_d = (state_q == ST_RUN) &&
               is_double_step({a, b}, {a ^ a_flip, b ^ b_flip});

    // The pulse lands one edge after the double change.
    illegal_d   = double_q;
    err_count_d = err_count_q;
    if (double_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_STARTUP;
      startup_cnt_q <= '0;
      double_q      <= 1'b0;
      illegal_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      startup_cnt_q <= startup_cnt_d;
      double_q      <= double_d;
      illegal_q     <= illegal_d;
      err_count_q   <= err_count_d;
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign stable    = a_idle && b_idle;
  assign illegal   = illegal_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_quad_conditioner.sv
// tb_quad_conditioner: directed and random stimulus against a window-based
// reference model. The model treats each clean output as "the synchronized
// pin level, accepted once it has differed from the output for
// DEBOUNCE_CYCLES consecutive samples".
module tb_quad_conditioner;

  localparam int D     = 4;
  localparam int CNT_W = 5;
  localparam int ERR_W = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_raw, b_raw;
  logic             a, b, ready, stable, illegal;
  logic [ERR_W-1:0] err_count;

  quad_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
    .a(a), .b(b), .ready(ready), .stable(stable), .illegal(illegal),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state. hist_* holds the pin level each edge fed into
  // the synchronizer (0 while in reset), newest last.
  bit hist_a[$];
  bit hist_b[$];
  bit m_a, m_b, m_stable, m_ill, m_dbl;
  int m_err, m_since;

  // Clean output toggles when the synchronized samples of the last D
  // edges (pin levels from edges n-D-1..n-2) all differ from it.
  function automatic bit window_flip(input bit h[$], input bit clean);
    int l = h.size();
    if (l < D + 2) return 1'b0;
    for (int i = l - D - 2; i <= l - 3; i++)
      if (h[i] == clean) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit chan_idle(input bit h[$], input bit clean, input bit fl);
    return fl || (h[h.size() - 3] == clean);
  endfunction

  task automatic model_edge(input bit ra, input bit rb, input bit rst);
    bit fa, fb, ready_before;
    if (rst) begin
      hist_a.delete(); hist_b.delete();
      repeat (2) begin hist_a.push_back(1'b0); hist_b.push_back(1'b0); end
      m_a = 0; m_b = 0; m_stable = 1; m_ill = 0; m_dbl = 0; m_err = 0; m_since = 0;
      return;
    end
    hist_a.push_back(ra);
    hist_b.push_back(rb);
    fa = window_flip(hist_a, m_a);
    fb = window_flip(hist_b, m_b);
    m_stable = chan_idle(hist_a, m_a, fa) && chan_idle(hist_b, m_b, fb);
    ready_before = (m_since >= D + 2);
    m_ill = m_dbl;
    if (m_ill && m_err < ERR_MAX) m_err++;
    m_dbl = fa && fb && ready_before;
    if (fa) m_a = !m_a;
    if (fb) m_b = !m_b;
    m_since++;
    if (hist_a.size() > 64) begin void'(hist_a.pop_front()); void'(hist_b.pop_front()); end
  endtask

  // Drive at the falling edge, clock once, compare at the next falling edge.
  task automatic tick(input bit ra, input bit rb, input bit rst);
    reset = rst; a_raw = ra; b_raw = rb;
    @(posedge clk);
    model_edge(ra, rb, rst);
    @(negedge clk);
    check("a",         32'(a),         32'(m_a));
    check("b",         32'(b),         32'(m_b));
    check("ready",     32'(ready),     32'(m_since >= D + 2));
    check("stable",    32'(stable),    32'(m_stable));
    check("illegal",   32'(illegal),   32'(m_ill));
    check("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic hold(input bit ra, input bit rb, input int n);
    for (int i = 0; i < n; i++) tick(ra, rb, 1'b0);
  endtask

  initial begin
    bit ra, rb;
    reset = 1'b1; a_raw = 1'b0; b_raw = 1'b0;

    // Power-up with quiet pins, then single-channel step and return.
    repeat (3) tick(0, 0, 1);
    hold(0, 0, 10);
    check("ready_after_startup", 32'(ready), 32'd1);
    hold(1, 0, 10);
    check("a_after_step", 32'(a), 32'd1);
    hold(0, 0, 10);

    // Glitch shorter than the debounce window is swallowed.
    hold(1, 0, 3);
    hold(0, 0, 8);
    check("a_after_glitch", 32'(a), 32'd0);

    // Four simultaneous changes: err_count saturates at 3.
    for (int k = 0; k < 4; k++) begin
      hold(1, 1, 10);
      hold(0, 0, 10);
    end
    check("err_saturated", 32'(err_count), 32'(ERR_MAX));

    // Release reset with both pins high: settle silently during startup.
    repeat (2) tick(1, 1, 1);
    hold(1, 1, 12);
    check("startup_err_quiet", 32'(err_count), 32'd0);

    // Reset two cycles into a pending A mismatch.
    repeat (2) tick(0, 0, 1);
    hold(0, 0, 10);
    hold(1, 0, 4);
    tick(1, 0, 1);
    hold(1, 0, 10);

    // Random segments with occasional resets.
    ra = 0; rb = 0;
    for (int seg = 0; seg < 400; seg++) begin
      case ($urandom_range(0, 3))
        0: ra = !ra;
        1: rb = !rb;
        2: begin ra = !ra; rb = !rb; end
        default: ;
      endcase
      if ($urandom_range(0, 60) == 0) tick(ra, rb, 1'b1);
      hold(ra, rb, $urandom_range(1, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
